// File: rtl/spi_slave.sv
// SPI target with synchronised sclk/ss_n/mosi, all four CPOL/CPHA modes,
// a one-entry TX holding buffer and a per-frame RX done tick.
module spi_slave #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              wr_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] dout_o,
  output logic              rx_done_o,
  output logic              underrun_o,
  input  logic              sclk_i,
  input  logic              ss_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StXfer} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_n_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_n_prev_q;
  logic                   sclk_s, ss_n_s, mosi_s;

  logic              cpol_q, cpha_q;
  logic [DATA_W-1:0] buf_q;
  logic              buf_full_q;
  logic [DATA_W-1:0] shift_tx_q, shift_rx_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic              done_q;
  logic [DATA_W-1:0] dout_q;
  logic              rx_done_q, underrun_q;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, load_en, deliver, wr_acc;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_n_s = ss_n_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise   = ~sclk_prev_q & sclk_s;
  assign sclk_fall   = sclk_prev_q & ~sclk_s;
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  // Sync chain resets low, so a select already held low across reset never looks like a fall.
  assign ss_fall = ss_n_prev_q & ~ss_n_s;
  assign wr_acc  = wr_i & ~buf_full_q;

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    deliver = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (ss_n_s) begin
          state_d = StIdle;
        end else begin
          load_en = 1'b1;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (done_q) begin
          deliver = 1'b1;
          state_d = ss_n_s ? StIdle : StLoad;
        end else if (ss_n_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      sclk_sync_q <= '0;
      ss_n_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_n_prev_q <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      shift_tx_q  <= '0;
      shift_rx_q  <= '0;
      bit_cnt_q   <= '0;
      done_q      <= 1'b0;
      dout_q      <= '0;
      rx_done_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      ss_n_sync_q <= {ss_n_sync_q[SYNC_STAGES-2:0], ss_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_s;
      ss_n_prev_q <= ss_n_s;
      rx_done_q   <= 1'b0;
      underrun_q  <= 1'b0;

      if (state_q == StIdle && ss_fall) begin
        cpol_q <= cpol_i;
        cpha_q <= cpha_i;
      end

      if (load_en) begin
        shift_tx_q <= buf_full_q ? buf_q : '0;
        underrun_q <= ~buf_full_q;
        buf_full_q <= 1'b0;
        bit_cnt_q  <= '0;
        done_q     <= 1'b0;
      end else if (state_q == StXfer && !done_q) begin
        if (sample_edge) begin
          shift_rx_q <= {shift_rx_q[DATA_W-2:0], mosi_s};
          bit_cnt_q  <= bit_cnt_q + CntW'(1);
          if (bit_cnt_q == CntW'(DATA_W - 1)) begin
            done_q <= 1'b1;
          end
        end
        // A shift edge before any sample belongs to the previous frame (cpha=0)
        // or presents the MSB (cpha=1); either way shift_tx must hold.
        if (shift_edge && bit_cnt_q != '0) begin
          shift_tx_q <= {shift_tx_q[DATA_W-2:0], 1'b0};
        end
      end

      if (deliver) begin
        dout_q    <= shift_rx_q;
        rx_done_q <= 1'b1;
        done_q    <= 1'b0;
      end

      // Written after the LOAD clear so a same-cycle write lands in the emptied buffer.
      if (wr_acc) begin
        buf_q      <= din_i;
        buf_full_q <= 1'b1;
      end
    end
  end

  assign tx_ready_o = ~buf_full_q;
  assign dout_o     = dout_q;
  assign rx_done_o  = rx_done_q;
  assign underrun_o = underrun_q;
  assign miso_o     = (state_q == StXfer) & shift_tx_q[DATA_W-1];
  assign miso_oe_o  = (state_q != StIdle);

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: table of single frames over all modes,
// plus hand sequences for abort, back-to-back and mid-frame reset.
module tb_spi_slave;

  localparam int W    = 8;
  localparam int HALF = 8;

  typedef struct {
    logic         cpol;
    logic         cpha;
    logic         wr;
    logic [W-1:0] tx;
    logic [W-1:0] rx;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset, cpol, cpha, wr, tx_ready, rx_done, underrun;
  logic         sclk, ss_n, mosi, miso, miso_oe;
  logic [W-1:0] din, dout;

  int           total = 0;
  int           bad = 0;
  int           n_done = 0;
  int           n_under = 0;
  int           done0, under0;
  logic [W-1:0] exp_q[$];
  vec_t         vecs[6];

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .cpol_i    (cpol),
    .cpha_i    (cpha),
    .din_i     (din),
    .wr_i      (wr),
    .tx_ready_o(tx_ready),
    .dout_o    (dout),
    .rx_done_o (rx_done),
    .underrun_o(underrun),
    .sclk_i    (sclk),
    .ss_n_i    (ss_n),
    .mosi_i    (mosi),
    .miso_o    (miso),
    .miso_oe_o (miso_oe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every rx_done pops the expected frame pushed when it was driven.
  always @(negedge clk) begin
    if (underrun === 1'b1) n_under++;
    if (rx_done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_done_unexpected: got pulse with dout=%0h want none", dout);
      end else begin
        check("rx_dout", {24'h0, dout}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_tx(input logic [W-1:0] b);
    din = b;
    wr  = 1'b1;
    tick(1);
    wr  = 1'b0;
  endtask

  task automatic select(input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sclk = pol;
    tick(HALF);
    ss_n = 1'b0;
    tick(HALF);
  endtask

  task automatic deselect();
    tick(HALF);
    ss_n = 1'b1;
    tick(HALF);
  endtask

  // Master side: drives mosi MSB-first and checks miso at each master sample edge.
  task automatic shift_bits(input int nbits, input logic [W-1:0] mo, input logic [W-1:0] exp_mi,
                            input string tag);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = mo[W-1-i];
        tick(HALF);
        sclk = ~sclk;
        check($sformatf("%s_miso_b%0d", tag, W-1-i), miso, exp_mi[W-1-i]);
        tick(HALF);
        sclk = ~sclk;
      end else begin
        tick(HALF);
        sclk = ~sclk;
        mosi = mo[W-1-i];
        tick(HALF);
        sclk = ~sclk;
        check($sformatf("%s_miso_b%0d", tag, W-1-i), miso, exp_mi[W-1-i]);
      end
    end
  endtask

  initial begin
    vecs[0] = '{cpol: 1'b0, cpha: 1'b0, wr: 1'b1, tx: 8'h3C, rx: 8'hA5};
    vecs[1] = '{cpol: 1'b0, cpha: 1'b1, wr: 1'b1, tx: 8'h3C, rx: 8'hA5};
    vecs[2] = '{cpol: 1'b1, cpha: 1'b0, wr: 1'b1, tx: 8'h3C, rx: 8'hA5};
    vecs[3] = '{cpol: 1'b1, cpha: 1'b1, wr: 1'b1, tx: 8'h3C, rx: 8'hA5};
    vecs[4] = '{cpol: 1'b0, cpha: 1'b0, wr: 1'b0, tx: 8'h00, rx: 8'hA5};
    vecs[5] = '{cpol: 1'b1, cpha: 1'b1, wr: 1'b0, tx: 8'h00, rx: 8'hC3};

    reset = 1'b1; cpol = 1'b0; cpha = 1'b0; din = '0; wr = 1'b0;
    sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    tick(4);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_dout", dout, 0);
    check("rst_rx_done", rx_done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    reset = 1'b0;
    tick(4);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].wr) begin
        write_tx(vecs[v].tx);
        check($sformatf("v%0d_tx_full", v), tx_ready, 0);
      end
      done0  = n_done;
      under0 = n_under;
      select(vecs[v].cpol, vecs[v].cpha);
      check($sformatf("v%0d_underrun", v), n_under - under0, vecs[v].wr ? 0 : 1);
      check($sformatf("v%0d_oe", v), miso_oe, 1);
      exp_q.push_back(vecs[v].rx);
      shift_bits(W, vecs[v].rx, vecs[v].wr ? vecs[v].tx : 8'h00, $sformatf("v%0d", v));
      deselect();
      check($sformatf("v%0d_dout", v), dout, vecs[v].rx);
      check($sformatf("v%0d_ndone", v), n_done - done0, 1);
      check($sformatf("v%0d_oe_idle", v), miso_oe, 0);
      check($sformatf("v%0d_pending", v), exp_q.size(), 0);
    end

    // Abort after 4 bits: no rx_done, buffered byte survives to the next frame.
    write_tx(8'hC3);
    done0 = n_done;
    select(1'b0, 1'b0);
    write_tx(8'h96);
    shift_bits(4, 8'hF0, 8'hC3, "abort");
    deselect();
    check("abort_ndone", n_done - done0, 0);
    check("abort_oe", miso_oe, 0);
    check("abort_buf_kept", tx_ready, 0);
    under0 = n_under;
    select(1'b0, 1'b0);
    check("abort_next_underrun", n_under - under0, 0);
    exp_q.push_back(8'h5A);
    shift_bits(W, 8'h5A, 8'h96, "after_abort");
    deselect();
    check("after_abort_dout", dout, 8'h5A);
    check("after_abort_ndone", n_done - done0, 1);

    // Back-to-back frames with ss_n held low.
    write_tx(8'h11);
    done0  = n_done;
    under0 = n_under;
    select(1'b0, 1'b0);
    write_tx(8'h22);
    exp_q.push_back(8'h81);
    shift_bits(W, 8'h81, 8'h11, "b2b0");
    check("b2b0_dout", dout, 8'h81);
    exp_q.push_back(8'h7E);
    shift_bits(W, 8'h7E, 8'h22, "b2b1");
    deselect();
    check("b2b_underrun", n_under - under0, 1);
    check("b2b_ndone", n_done - done0, 2);
    check("b2b1_dout", dout, 8'h7E);
    check("b2b_pending", exp_q.size(), 0);

    // Reset at bit 5 with ss_n still low.
    write_tx(8'h44);
    done0  = n_done;
    under0 = n_under;
    select(1'b1, 1'b0);
    shift_bits(5, 8'h00, 8'h44, "pre_rst");
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_rx_done", rx_done, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_miso", miso, 0);
    check("mid_rst_miso_oe", miso_oe, 0);
    cpol = 1'b1;
    cpha = 1'b0;
    shift_bits(3, 8'hFF, 8'h00, "post_rst");
    tick(HALF);
    check("post_rst_oe", miso_oe, 0);
    check("post_rst_ndone", n_done - done0, 0);
    ss_n = 1'b1;
    tick(HALF);
    write_tx(8'hE7);
    under0 = n_under;
    select(1'b0, 1'b1);
    check("rst_next_underrun", n_under - under0, 0);
    exp_q.push_back(8'hFF);
    shift_bits(W, 8'hFF, 8'hE7, "rst_next");
    deselect();
    check("rst_next_dout", dout, 8'hFF);
    check("rst_next_ndone", n_done - done0, 1);
    check("final_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
